periph_timer_gpio: RTL

- Peripheral slave on the CPU data-memory port. Serves the upper half of the word address space (DataMem_Address[29]=1) and returns its read data on per_dout.
- Contains a prescaled 32-bit down-counter timer and a GPIO_W-bit GPIO port with rising-edge capture.
- Drives two interrupt lines that are wired into the processor's general-purpose Interrupts inputs.

---
 rtl/periph_timer_gpio.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/periph_timer_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : periph_timer_gpio
// Purpose  : Data-memory-mapped peripheral. Holds a prescaled 32-bit
//            down-counter timer and a GPIO port with rising-edge capture.
//            Drives level timer and GPIO interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module periph_timer_gpio #(
  parameter int GPIO_W     = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [29:0]       DataMem_Address,
  input  logic              DataMem_Read,
  input  logic [3:0]        DataMem_Write,
  input  logic [31:0]       DataMem_Out,
  output logic [31:0]       per_dout,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              gpio_irq
);

  localparam logic [3:0] OFF_CTRL      = 4'h0;
  localparam logic [3:0] OFF_STATUS    = 4'h1;
  localparam logic [3:0] OFF_LOAD      = 4'h2;
  localparam logic [3:0] OFF_COUNT     = 4'h3;
  localparam logic [3:0] OFF_PRESCALE  = 4'h4;
  localparam logic [3:0] OFF_GPIO_OUT  = 4'h5;
  localparam logic [3:0] OFF_GPIO_IN   = 4'h6;
  localparam logic [3:0] OFF_GPIO_EDGE = 4'h7;
  localparam logic [3:0] OFF_GPIO_MASK = 4'h8;

  // Architectural state
  logic [3:0]            ctrl;       // [0] EN [1] AUTO_RELOAD [2] TIMER_IE [3] GPIO_IE
  logic                  timer_exp;
  logic [31:0]           load_val;
  logic [31:0]           count;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [GPIO_W-1:0]     gpio_mask;
  logic [GPIO_W-1:0]     gpio_edge;
  logic [GPIO_W-1:0]     sync_1;
  logic [GPIO_W-1:0]     sync_2;
  logic [GPIO_W-1:0]     sync_prev;

  // Bus decode
  logic        sel;
  logic [3:0]  off;
  logic        wr_any;
  logic [31:0] byte_mask;
  logic [31:0] wdata_m;
  logic        wr_ctrl, wr_status, wr_load, wr_count;
  logic        wr_prescale, wr_gpio_out, wr_gpio_edge, wr_gpio_mask;
  logic        unused_addr_bits;

  assign sel              = DataMem_Address[29];
  assign off              = DataMem_Address[3:0];
  assign unused_addr_bits = ^DataMem_Address[28:4];
  assign wr_any           = sel & (|DataMem_Write);
  assign byte_mask        = {{8{DataMem_Write[3]}}, {8{DataMem_Write[2]}},
                             {8{DataMem_Write[1]}}, {8{DataMem_Write[0]}}};
  assign wdata_m          = DataMem_Out & byte_mask;

  assign wr_ctrl      = wr_any & (off == OFF_CTRL);
  assign wr_status    = wr_any & (off == OFF_STATUS);
  assign wr_load      = wr_any & (off == OFF_LOAD);
  assign wr_count     = wr_any & (off == OFF_COUNT);
  assign wr_prescale  = wr_any & (off == OFF_PRESCALE);
  assign wr_gpio_out  = wr_any & (off == OFF_GPIO_OUT);
  assign wr_gpio_edge = wr_any & (off == OFF_GPIO_EDGE);
  assign wr_gpio_mask = wr_any & (off == OFF_GPIO_MASK);

  // Timer events
  logic tick;
  logic expire;

  assign tick   = ctrl[0] & (presc_cnt == prescale);
  assign expire = tick & (count == 32'd0);

  // Next CTRL: software byte write wins over the one-shot EN auto-clear
  logic [3:0] ctrl_next;

  always_comb begin
    ctrl_next = ctrl;
    if (wr_ctrl) begin
      ctrl_next = (ctrl & ~byte_mask[3:0]) | wdata_m[3:0];
    end
    if (expire && !ctrl[1] && !(wr_ctrl && DataMem_Write[0])) begin
      ctrl_next[0] = 1'b0;
    end
  end

  // Plain configuration registers with byte-lane merge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl      <= '0;
      load_val  <= '0;
      prescale  <= '0;
      gpio_out  <= '0;
      gpio_mask <= '0;
    end else begin
      ctrl <= ctrl_next;
      if (wr_load)      load_val  <= (load_val & ~byte_mask) | wdata_m;
      if (wr_prescale)  prescale  <= (prescale & ~byte_mask[PRESCALE_W-1:0])
                                     | wdata_m[PRESCALE_W-1:0];
      if (wr_gpio_out)  gpio_out  <= (gpio_out & ~byte_mask[GPIO_W-1:0])
                                     | wdata_m[GPIO_W-1:0];
      if (wr_gpio_mask) gpio_mask <= (gpio_mask & ~byte_mask[GPIO_W-1:0])
                                     | wdata_m[GPIO_W-1:0];
    end
  end

  // Prescaler and down-counter; a COUNT write overrides a same-cycle tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_cnt <= '0;
      count     <= '0;
    end else begin
      if (wr_count) begin
        presc_cnt <= '0;
        count     <= (count & ~byte_mask) | wdata_m;
      end else begin
        if (ctrl[0]) begin
          presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
        end
        if (tick) begin
          if (count != 32'd0) begin
            count <= count - 32'd1;
          end else if (ctrl[1]) begin
            count <= load_val;
          end
        end
      end
    end
  end

  // Expiry flag: hardware set beats a same-cycle write-1-to-clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_exp <= 1'b0;
    end else begin
      timer_exp <= expire | (timer_exp & ~(wr_status & wdata_m[0]));
    end
  end

  // Two-flop input synchroniser, delayed copy and edge flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1    <= '0;
      sync_2    <= '0;
      sync_prev <= '0;
      gpio_edge <= '0;
    end else begin
      sync_1    <= gpio_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      gpio_edge <= (sync_2 & ~sync_prev)
                 | (gpio_edge & ~(wr_gpio_edge ? wdata_m[GPIO_W-1:0] : '0));
    end
  end

  // Registered interrupt outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_irq <= 1'b0;
      gpio_irq  <= 1'b0;
    end else begin
      timer_irq <= timer_exp & ctrl[2];
      gpio_irq  <= ctrl[3] & (|(gpio_edge & gpio_mask));
    end
  end

  // Read mux; unused bits and unmapped offsets return zero
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL:      rd_val[3:0]            = ctrl;
      OFF_STATUS:    rd_val[0]              = timer_exp;
      OFF_LOAD:      rd_val                 = load_val;
      OFF_COUNT:     rd_val                 = count;
      OFF_PRESCALE:  rd_val[PRESCALE_W-1:0] = prescale;
      OFF_GPIO_OUT:  rd_val[GPIO_W-1:0]     = gpio_out;
      OFF_GPIO_IN:   rd_val[GPIO_W-1:0]     = sync_2;
      OFF_GPIO_EDGE: rd_val[GPIO_W-1:0]     = gpio_edge;
      OFF_GPIO_MASK: rd_val[GPIO_W-1:0]     = gpio_mask;
      default:       rd_val                 = '0;
    endcase
  end

  // Read data register: loads on a selected read, otherwise holds
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_dout <= '0;
    end else if (sel && DataMem_Read) begin
      per_dout <= rd_val;
    end
  end

endmodule
`default_nettype wire
